// File: rtl/ex_pkg.sv
// Shared opcode/result-class encodings, the multiply/divide FSM state type
// and the reset-assert level used by the execute stage.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

package ex_pkg;

    localparam logic RST_ENABLE = `RstEnable;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLL   = 8'h7C;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_ADD   = 8'h20;
    localparam logic [7:0] OP_ADDU  = 8'h21;
    localparam logic [7:0] OP_SUB   = 8'h22;
    localparam logic [7:0] OP_SUBU  = 8'h23;
    localparam logic [7:0] OP_SLT   = 8'h2A;
    localparam logic [7:0] OP_SLTU  = 8'h2B;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_md_op(input logic [7:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply (shift-add) and divide (restoring), one bit per cycle,
// on operand magnitudes; the result sign is applied while in DONE.
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic            is_div,
    input  logic            cancel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output md_state_e       state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    md_state_e       state_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc_hi, acc_lo, opnd_b;
    logic            div_q, neg_hi, neg_lo;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod_neg;

    assign sign_a = is_signed & op_a[XLEN-1];
    assign sign_b = is_signed & op_b[XLEN-1];
    assign mag_a  = sign_a ? -op_a : op_a;
    assign mag_b  = sign_b ? -op_b : op_b;
    assign state  = state_q;

    // acc_hi:acc_lo is the running product, or remainder:quotient when dividing.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_b};
        if (div_q) begin
            step_hi = div_ge ? XLEN'(div_shift - {1'b0, opnd_b}) : div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_neg = -{acc_hi, acc_lo};
        hi = acc_hi;
        lo = acc_lo;
        if (state_q == MD_DONE) begin
            if (!div_q) begin
                if (neg_lo) {hi, lo} = prod_neg;
            end else begin
                if (neg_hi) hi = -acc_hi;
                if (neg_lo) lo = -acc_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd_b  <= '0;
            div_q   <= 1'b0;
            neg_hi  <= 1'b0;
            neg_lo  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start && !cancel) begin
                        cnt   <= '0;
                        div_q <= is_div;
                        if (is_div && op_b == '0) begin
                            // Divide by zero finishes immediately with a fixed result.
                            acc_hi  <= op_a;
                            acc_lo  <= '1;
                            neg_hi  <= 1'b0;
                            neg_lo  <= 1'b0;
                            state_q <= MD_DONE;
                        end else begin
                            acc_hi  <= '0;
                            acc_lo  <= mag_a;
                            opnd_b  <= mag_b;
                            neg_hi  <= sign_a;
                            neg_lo  <= sign_a ^ sign_b;
                            state_q <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (cancel) begin
                        state_q <= MD_IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        if (cnt == LAST) state_q <= MD_DONE;
                        else             cnt     <= cnt + 1'b1;
                    end
                end
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_param.sv
// Execute stage: single-cycle logic/shift/arith results plus a stalling
// multiply/divide unit that writes HI/LO.
module ex_param
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int MD_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [XLEN-1:0]   reg1_i,
    input  logic [XLEN-1:0]   reg2_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              cancel_i,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              hilo_we_o,
    output logic [XLEN-1:0]   hi_o,
    output logic [XLEN-1:0]   lo_o,
    output logic              ov_o,
    output logic              stallreq_o
);

    localparam int SW = $clog2(XLEN);

    logic            in_rst;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] sum, diff, logic_res, shift_res, arith_res;
    logic            add_ov, sub_ov, ov;
    logic            md_op, md_signed, md_div, md_issue;
    logic [XLEN-1:0] md_hi, md_lo;
    md_state_e       md_state;

    assign in_rst    = (rst_n == RST_ENABLE);
    assign shamt     = reg1_i[SW-1:0];
    assign sum       = reg1_i + reg2_i;
    assign diff      = reg1_i - reg2_i;
    assign add_ov    = (reg1_i[XLEN-1] == reg2_i[XLEN-1]) && (sum[XLEN-1] != reg1_i[XLEN-1]);
    assign sub_ov    = (reg1_i[XLEN-1] != reg2_i[XLEN-1]) && (diff[XLEN-1] != reg1_i[XLEN-1]);
    assign ov        = ((aluop_i == OP_ADD) && add_ov) || ((aluop_i == OP_SUB) && sub_ov);

    // With the unit disabled, MD opcodes fall through as unknown ops.
    assign md_op     = (MD_EN != 0) && is_md_op(aluop_i);
    assign md_signed = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
    assign md_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign md_issue  = md_op && !cancel_i && (md_state == MD_IDLE);

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        case (aluop_i)
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            default: ;
        endcase
        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << shamt;
            OP_SRL:  shift_res = reg2_i >> shamt;
            OP_SRA:  shift_res = $signed(reg2_i) >>> shamt;
            default: ;
        endcase
        case (aluop_i)
            OP_ADD, OP_ADDU: arith_res = sum;
            OP_SUB, OP_SUBU: arith_res = diff;
            OP_SLT:  arith_res = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
            OP_SLTU: arith_res = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
            default: ;
        endcase
    end

    always_comb begin
        wd_o    = '0;
        wreg_o  = 1'b0;
        wdata_o = '0;
        ov_o    = 1'b0;
        if (!in_rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i && !ov && !md_op;
            ov_o   = ov;
            case (alusel_i)
                SEL_LOGIC: wdata_o = logic_res;
                SEL_SHIFT: wdata_o = shift_res;
                SEL_ARITH: wdata_o = arith_res;
                default:   wdata_o = '0;
            endcase
        end
    end

    assign stallreq_o = !in_rst && (md_issue || (md_state == MD_BUSY));
    assign hilo_we_o  = !in_rst && (md_state == MD_DONE);
    assign hi_o       = in_rst ? '0 : md_hi;
    assign lo_o       = in_rst ? '0 : md_lo;

    ex_muldiv #(.XLEN(XLEN)) u_md (
        .clk       (clk),
        .rst       (in_rst),
        .start     (md_op),
        .is_signed (md_signed),
        .is_div    (md_div),
        .cancel    (cancel_i),
        .op_a      (reg1_i),
        .op_b      (reg2_i),
        .hi        (md_hi),
        .lo        (md_lo),
        .state     (md_state)
    );

endmodule

// File: tb/tb_ex_param.sv
// Bench for ex_param: a 32-bit instance for the main features and a 16-bit
// instance for back-to-back multiplies.
module tb_ex_param;
    import ex_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        wreg, cancel;
    logic [4:0]  wd_o;
    logic        wreg_o, hilo_we_o, ov_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    logic [7:0]  b_aluop;
    logic [15:0] b_reg1, b_reg2;
    logic [4:0]  b_wd_o;
    logic        b_wreg_o, b_hilo_we_o, b_ov_o, b_stallreq_o;
    logic [15:0] b_wdata_o, b_hi_o, b_lo_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [63:0] exp_q[$];

    ex_param #(.XLEN(32), .REG_AW(5), .MD_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .aluop_i(aluop), .alusel_i(alusel),
        .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .cancel_i(cancel),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hilo_we_o(hilo_we_o),
        .hi_o(hi_o), .lo_o(lo_o), .ov_o(ov_o), .stallreq_o(stallreq_o)
    );

    ex_param #(.XLEN(16), .REG_AW(5), .MD_EN(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .aluop_i(b_aluop), .alusel_i(SEL_LOGIC),
        .reg1_i(b_reg1), .reg2_i(b_reg2), .wd_i(5'd3), .wreg_i(1'b1), .cancel_i(1'b0),
        .wd_o(b_wd_o), .wreg_o(b_wreg_o), .wdata_o(b_wdata_o), .hilo_we_o(b_hilo_we_o),
        .hi_o(b_hi_o), .lo_o(b_lo_o), .ov_o(b_ov_o), .stallreq_o(b_stallreq_o)
    );

    function automatic logic [31:0] ref_logic(input logic [7:0] op, input logic [31:0] a, b);
        case (op)
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_NOR:  return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] ref_shift(input logic [7:0] op, input logic [31:0] a, b);
        logic [4:0] sh;
        sh = a[4:0];
        case (op)
            OP_SLL:  return b << sh;
            OP_SRL:  return b >> sh;
            default: return $signed(b) >>> sh;
        endcase
    endfunction

    task automatic drive_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, b);
        @(posedge clk); #1;
        aluop = op; alusel = sel; reg1 = a; reg2 = b;
    endtask

    // Runs one MD op on the 32-bit instance and records what it did per cycle (k=0 is issue).
    task automatic md_run(input logic [7:0] op, input logic [31:0] a, b,
                          input int cancel_at, input int rst_at,
                          output int stall_n, output int last_stall, output int pulse_n,
                          output int pulse_k, output logic [63:0] got,
                          output logic wreg_t0, output logic zero_at_rst);
        stall_n = 0; last_stall = -1; pulse_n = 0; pulse_k = -1; got = '0;
        wreg_t0 = 1'b1; zero_at_rst = 1'b0;
        @(posedge clk); #1;
        aluop = op; alusel = SEL_NOP; reg1 = a; reg2 = b; wd = 5'd9; wreg = 1'b1; cancel = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (stallreq_o) begin stall_n++; last_stall = k; end
            if (hilo_we_o) begin pulse_n++; pulse_k = k; got = {hi_o, lo_o}; end
            if (k == 0) wreg_t0 = wreg_o;
            if (k == rst_at)
                zero_at_rst = ({wdata_o, hi_o, lo_o, hilo_we_o, ov_o, stallreq_o, wreg_o, wd_o} === '0);
            @(posedge clk); #1;
            if (k == 0) begin
                aluop = OP_OR; alusel = SEL_LOGIC; reg1 = $urandom | 32'h1; reg2 = $urandom;
            end
            cancel = (k + 1 == cancel_at);
            rst_n  = (k + 1 == rst_at);
        end
        cancel = 1'b0; rst_n = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive_op(OP_OR, SEL_LOGIC, 32'hFFFF_FFFF, 32'h1234_5678);
        wd = 5'd5; wreg = 1'b1; b_aluop = OP_MULTU;
        @(negedge clk);
        tests_run++;
        if ({wdata_o, hi_o, lo_o, hilo_we_o, ov_o, stallreq_o, wreg_o, wd_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wdata=%h wreg=%b wd=%h stall=%b, expected all zero",
                     wdata_o, wreg_o, wd_o, stallreq_o);
        end
        drive_op(OP_MULTU, SEL_NOP, 32'd3, 32'd4);
        @(negedge clk);
        tests_run++;
        if ({stallreq_o, hilo_we_o, b_stallreq_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_md_stall: got stall=%b we=%b stall16=%b, expected 0", stallreq_o, hilo_we_o, b_stallreq_o);
        end
        tests_run++;
        if ({b_wdata_o, b_hi_o, b_lo_o, b_hilo_we_o, b_ov_o, b_wreg_o, b_wd_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs16: got wdata=%h wd=%h, expected all zero", b_wdata_o, b_wd_o);
        end
        b_aluop = OP_NOP;
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    task automatic test_logic();
        logic [7:0]  to[4] = '{OP_OR, OP_AND, OP_NOR, OP_XOR};
        logic [31:0] ta[4] = '{32'hF0F0_0000, 32'hFF00_FF00, 32'h1234_5678, 32'hAAAA_5555};
        logic [31:0] tb[4] = '{32'h0000_0F0F, 32'h0F0F_0F0F, 32'hF000_0000, 32'hFFFF_0000};
        logic [31:0] te[4] = '{32'hF0F0_0F0F, 32'h0F00_0F00, 32'h0DCB_A987, 32'h5555_5555};
        logic [31:0] a, b;
        logic [63:0] e;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                a = ta[i]; b = tb[i];
                exp_q.push_back({32'h0, te[i]});
            end else begin
                a = $urandom; b = $urandom;
                exp_q.push_back({32'h0, ref_logic(to[i % 4], a, b)});
            end
            wd = 5'(i); wreg = 1'b1;
            drive_op(to[i % 4], SEL_LOGIC, a, b);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (wdata_o !== e[31:0]) begin
                tests_failed++;
                $display("FAIL logic[%0d] op=%h: got %h, expected %h", i, to[i % 4], wdata_o, e[31:0]);
            end
        end
        tests_run++;
        if ({wd_o, wreg_o, ov_o} !== {5'd11, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL logic_wd_wreg: got wd=%h wreg=%b ov=%b, expected wd=0b wreg=1 ov=0", wd_o, wreg_o, ov_o);
        end
    endtask

    task automatic test_shift();
        logic [7:0]  to[4] = '{OP_SRA, OP_SLL, OP_SRL, OP_SRA};
        logic [31:0] ta[4] = '{32'd4, 32'd33, 32'd31, 32'd40};
        logic [31:0] tb[4] = '{32'h8000_0000, 32'h4000_0001, 32'h8000_0000, 32'h7F00_0000};
        logic [31:0] te[4] = '{32'hF800_0000, 32'h8000_0002, 32'h0000_0001, 32'h007F_0000};
        logic [7:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;
        for (int i = 0; i < 10; i++) begin
            op = to[i % 4];
            if (i < 4) begin
                a = ta[i]; b = tb[i];
                exp_q.push_back({32'h0, te[i]});
            end else begin
                a = $urandom_range(0, 63); b = $urandom;
                exp_q.push_back({32'h0, ref_shift(op, a, b)});
            end
            drive_op(op, SEL_SHIFT, a, b);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (wdata_o !== e[31:0]) begin
                tests_failed++;
                $display("FAIL shift[%0d] op=%h: got %h, expected %h", i, op, wdata_o, e[31:0]);
            end
        end
    endtask

    task automatic test_arith();
        logic [7:0]  to[10] = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_ADD, OP_SUB, OP_SLT, OP_SLTU};
        logic [31:0] ta[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd5, 32'd3, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[10] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd1, 32'd1, 32'hFFFF_FFFD,
                                32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] td[10] = '{32'h0, 32'h8000_0000, 32'h0, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd2,
                                32'h0, 32'd1, 32'd0};
        logic        tov[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [63:0] e;
        wreg = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!tov[i]) exp_q.push_back({32'h0, td[i]});
            drive_op(to[i], SEL_ARITH, ta[i], tb[i]);
            #1;
            tests_run++;
            if ({ov_o, wreg_o} !== {tov[i], !tov[i]}) begin
                tests_failed++;
                $display("FAIL arith_flags[%0d] op=%h: got ov=%b wreg=%b, expected ov=%b wreg=%b",
                         i, to[i], ov_o, wreg_o, tov[i], !tov[i]);
            end
            if (!tov[i]) begin
                e = exp_q.pop_front();
                tests_run++;
                if (wdata_o !== e[31:0]) begin
                    tests_failed++;
                    $display("FAIL arith[%0d] op=%h: got %h, expected %h", i, to[i], wdata_o, e[31:0]);
                end
            end
        end
    endtask

    task automatic test_sel_default();
        logic [2:0] sels[2] = '{SEL_NOP, 3'b111};
        logic [63:0] e;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(64'h0);
            drive_op(OP_OR, sels[i], 32'hFFFF_0000, 32'h0000_FFFF);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (wdata_o !== e[31:0]) begin
                tests_failed++;
                $display("FAIL sel_default[%0d]: got %h, expected %h", i, wdata_o, e[31:0]);
            end
        end
    endtask

    task automatic test_mult();
        int sn, ls, pn, pk;
        logic [63:0] got, e;
        logic w0, z;
        logic [31:0] a, b;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
        md_run(OP_MULT, 32'hFFFF_FFFD, 32'd5, -1, -1, sn, ls, pn, pk, got, w0, z);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== e || pn != 1) begin
            tests_failed++;
            $display("FAIL mult_neg3x5: got %h (pulses %0d), expected %h", got, pn, e);
        end
        tests_run++;
        if (sn != 33 || ls != 32 || pk != 33) begin
            tests_failed++;
            $display("FAIL mult_timing: got stall=%0d last=%0d pulse_at=%0d, expected 33/32/33", sn, ls, pk);
        end
        tests_run++;
        if (w0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mult_wreg: got %b, expected 0", w0);
        end
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            if (i < 2) exp_q.push_back({32'h0, a} * {32'h0, b});
            else       exp_q.push_back($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            md_run((i < 2) ? OP_MULTU : OP_MULT, a, b, -1, -1, sn, ls, pn, pk, got, w0, z);
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e || pn != 1 || pk != 33) begin
                tests_failed++;
                $display("FAIL mult_rand[%0d] %h*%h: got %h at %0d, expected %h at 33", i, a, b, got, pk, e);
            end
        end
    endtask

    task automatic test_div();
        int sn, ls, pn, pk;
        logic [63:0] got, e;
        logic w0, z;
        logic [31:0] a, b;
        logic signed [31:0] sa, sb;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        exp_q.push_back({32'h0, 32'h8000_0000});
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin a = 32'hFFFF_FFF9; b = 32'd2; end
            else if (i == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (i < 4) begin
                a = $urandom; b = $urandom_range(1, 65535);
                exp_q.push_back({a % b, a / b});
            end else begin
                sa = $signed($urandom); sb = $urandom_range(2, 1000);
                if ($urandom_range(0, 1) == 1) sb = -sb;
                a = sa; b = sb;
                exp_q.push_back({sa % sb, sa / sb});
            end
            md_run((i == 2 || i == 3) ? OP_DIVU : OP_DIV, a, b, -1, -1, sn, ls, pn, pk, got, w0, z);
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e || pn != 1 || pk != 33 || sn != 33) begin
                tests_failed++;
                $display("FAIL div[%0d] %h/%h: got %h at %0d (stall %0d), expected %h at 33", i, a, b, got, pk, sn, e);
            end
        end
    endtask

    task automatic test_div_zero();
        int sn, ls, pn, pk;
        logic [63:0] got, e;
        logic w0, z;
        exp_q.push_back({32'd9, 32'hFFFF_FFFF});
        md_run(OP_DIVU, 32'd9, 32'd0, -1, -1, sn, ls, pn, pk, got, w0, z);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== e || pn != 1 || pk != 1 || sn != 1) begin
            tests_failed++;
            $display("FAIL divu_zero: got %h at %0d (stall %0d), expected %h at 1 (stall 1)", got, pk, sn, e);
        end
        exp_q.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF});
        md_run(OP_DIV, 32'hFFFF_FFFB, 32'd0, -1, -1, sn, ls, pn, pk, got, w0, z);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== e || pn != 1 || pk != 1) begin
            tests_failed++;
            $display("FAIL div_zero_signed: got %h at %0d, expected %h at 1", got, pk, e);
        end
    endtask

    task automatic test_cancel();
        int sn, ls, pn, pk;
        logic [63:0] got, e;
        logic w0, z;
        md_run(OP_DIVU, 32'd100, 32'd7, 10, -1, sn, ls, pn, pk, got, w0, z);
        tests_run++;
        if (pn != 0 || sn != 11 || ls != 10) begin
            tests_failed++;
            $display("FAIL cancel_busy: got pulses=%0d stall=%0d last=%0d, expected 0/11/10", pn, sn, ls);
        end
        exp_q.push_back(64'd42);
        md_run(OP_MULTU, 32'd6, 32'd7, -1, -1, sn, ls, pn, pk, got, w0, z);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== e || pn != 1 || pk != 33) begin
            tests_failed++;
            $display("FAIL after_cancel: got %h at %0d, expected %h at 33", got, pk, e);
        end
    endtask

    task automatic test_reset_mid();
        int sn, ls, pn, pk;
        logic [63:0] got;
        logic w0, z;
        md_run(OP_MULTU, 32'd1234, 32'd5678, -1, 5, sn, ls, pn, pk, got, w0, z);
        tests_run++;
        if (z !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got zero=%b, expected 1", z);
        end
        tests_run++;
        if (pn != 0 || sn != 5) begin
            tests_failed++;
            $display("FAIL reset_mid_abort: got pulses=%0d stall=%0d, expected 0/5", pn, sn);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, b1, a2, b2;
        logic [63:0] e;
        int pulses, pk0, pk1;
        a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
        exp_q.push_back({32'h0, {16'h0, a1} * {16'h0, b1}});
        exp_q.push_back({32'h0, {16'h0, a2} * {16'h0, b2}});
        pulses = 0; pk0 = -1; pk1 = -1;
        @(posedge clk); #1;
        b_aluop = OP_MULTU; b_reg1 = a1; b_reg2 = b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (b_hilo_we_o) begin
                if (pulses == 0) pk0 = k; else pk1 = k;
                pulses++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_extra_pulse: got pulse at %0d, expected none", k);
                end else begin
                    e = exp_q.pop_front();
                    if ({b_hi_o, b_lo_o} !== e[31:0]) begin
                        tests_failed++;
                        $display("FAIL b2b_product[%0d]: got %h, expected %h", pulses, {b_hi_o, b_lo_o}, e[31:0]);
                    end
                end
            end
            @(posedge clk); #1;
            if (k == 0) begin b_reg1 = a2; b_reg2 = b2; end
            if (k == 18) b_aluop = OP_NOP;
        end
        tests_run++;
        if (pulses != 2 || pk0 != 17 || pk1 - pk0 != 18) begin
            tests_failed++;
            $display("FAIL b2b_timing: got pulses=%0d at %0d,%0d, expected 2 at 17,35", pulses, pk0, pk1);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests_run++;
            tests_failed++;
            $display("FAIL b2b_missing: got no pulse, expected product %h", e[31:0]);
        end
    endtask

    initial begin
        rst_n = 1'b1; aluop = OP_NOP; alusel = SEL_NOP; reg1 = '0; reg2 = '0;
        wd = '0; wreg = 1'b0; cancel = 1'b0;
        b_aluop = OP_NOP; b_reg1 = '0; b_reg2 = '0;
        test_reset();
        test_logic();
        test_shift();
        test_arith();
        test_sel_default();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_param.md
EX_PARAM -- requirements
Module: ex_param

Interface
REQ-001 Parameter XLEN, default 32, shall set the datapath width; legal values are 16, 32 and 64.
REQ-002 Parameter REG_AW, default 5, shall set the destination register address width.
REQ-003 Parameter MD_EN, default 1, shall enable the multiply/divide unit; when 0, MD ops behave as unknown ops.
REQ-004 Ports shall be: clk in 1, rising-edge clock; rst_n in 1, synchronous active-high reset, asserted when equal to `RstEnable (1'b1).
REQ-005 Ports shall be: aluop_i in 8, operation code; alusel_i in 3, result class; reg1_i in XLEN, operand 1; reg2_i in XLEN, operand 2.
REQ-006 Ports shall be: wd_i in REG_AW, destination register; wreg_i in 1, write enable; cancel_i in 1, pipeline flush.
REQ-007 Ports shall be: wd_o out REG_AW; wreg_o out 1; wdata_o out XLEN, result.
REQ-008 Ports shall be: hilo_we_o out 1, HI/LO write strobe; hi_o out XLEN; lo_o out XLEN.
REQ-009 Ports shall be: ov_o out 1, signed overflow flag; stallreq_o out 1, pipeline stall request.

Function
REQ-010 Logic ops OR/AND/NOR/XOR shall complete combinationally in the issue cycle.
REQ-011 Shift ops SLL/SRL/SRA shall shift reg2_i by reg1_i[$clog2(XLEN)-1:0]; SRA shall sign-fill.
REQ-012 Arith ops ADD/ADDU/SUB/SUBU/SLT/SLTU shall be combinational; SLT/SLTU shall yield 1 or 0 zero-extended.
REQ-013 On ADD/SUB signed overflow, ov_o shall be 1 and wreg_o forced 0; ADDU/SUBU shall never set ov_o.
REQ-014 wd_o shall equal wd_i; wreg_o shall equal wreg_i except per REQ-013 and for MD ops, where it shall be 0.
REQ-015 wdata_o shall be selected by alusel_i (LOGIC, SHIFT, ARITH); any other class shall yield zero.
REQ-016 MULT/MULTU/DIV/DIVU shall use an FSM with states IDLE, BUSY, DONE.
REQ-017 IDLE->BUSY shall occur on an MD op with cancel_i=0; issue cycle is T.
REQ-018 Multiply shall be shift-add, 1 bit/cycle, over XLEN BUSY cycles (T+1..T+XLEN), then DONE at T+XLEN+1.
REQ-019 Divide shall be restoring, 1 quotient bit/cycle, with the same timing as multiply.
REQ-020 Signed MD ops shall operate on magnitudes; the result sign shall be fixed in DONE (remainder takes dividend sign).
REQ-021 DIV/DIVU with divisor zero shall go IDLE->DONE at T+1 with lo_o all-ones and hi_o = dividend.
REQ-022 Signed DIV of most-negative by -1 shall give lo_o = most-negative and hi_o = 0, with no flag.
REQ-023 stallreq_o shall be 1 combinationally in T and through every BUSY cycle, and 0 in DONE.
REQ-024 In DONE, hilo_we_o shall be 1 for exactly one cycle; multiply gives {hi_o,lo_o} = 2*XLEN product; divide gives lo_o = quotient, hi_o = remainder.
REQ-025 DONE shall always return to IDLE, ignoring the held MD op, so that a back-to-back MD op starts one cycle later.
REQ-026 cancel_i=1 in BUSY shall return to IDLE next cycle with no hilo_we_o pulse; in IDLE it shall suppress issue.
REQ-027 Operand registers shall capture reg1_i/reg2_i only at T; later input changes shall not affect the result.

Reset
REQ-028 While rst_n=1, the FSM shall enter IDLE and the iteration counter and accumulators shall clear.
REQ-029 While rst_n=1, wdata_o, hi_o, lo_o, hilo_we_o, ov_o, stallreq_o and wreg_o shall be 0, and wd_o shall be 0.
REQ-030 Reset mid-BUSY shall abort the operation with no hilo_we_o pulse.

Structure
REQ-031 A shared package ex_pkg shall hold the aluop/alusel codes, the FSM state enum and `RstEnable.
REQ-032 The MD datapath and FSM shall be a sub-module ex_muldiv; combinational ops shall stay in ex_param.

Verification
REQ-033 ADD 0x7FFFFFFF + 1 -> ov_o=1, wreg_o=0; ADDU with the same operands -> wdata_o=0x80000000, ov_o=0.
REQ-034 SRA with reg2=0x80000000 and reg1=4 -> wdata_o=0xF8000000; SLL with reg1=33 -> shift by 1.
REQ-035 MULT -3 x 5 at XLEN=32 -> stallreq_o high 33 cycles, hilo_we_o pulse at T+33, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
REQ-036 DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 9 / 0 -> DONE at T+1, lo_o=0xFFFFFFFF, hi_o=9.
REQ-037 cancel_i pulsed at T+10 of a DIVU -> IDLE at T+11, no hilo_we_o; rst_n at T+5 of a MULTU -> all outputs 0.
REQ-038 Two back-to-back MULTU ops at XLEN=16 -> two hilo_we_o pulses 18 cycles apart, both with correct products.
